// File: rtl/ps2_key_decoder_if.sv
// Byte stream in, game-control levels and pulses out, between a PS/2 receiver and the decoder.
interface ps2_key_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       move_left;
    logic       move_right;
    logic       fire;
    logic       pause;
    logic       seq_error;

    modport master (
        output ps2_data, ps2_valid,
        input  move_left, move_right, fire, pause, seq_error
    );

    modport slave (
        input  ps2_data, ps2_valid,
        output move_left, move_right, fire, pause, seq_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: tracks make/break/extended prefixes and turns
// A/D/arrows/space/P into move, fire and pause controls, with a prefix timeout.
module ps2_key_decoder #(
    parameter logic [20:0] TIMEOUT_CYCLES = 21'd1250000
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    ps2_key_decoder_if.slave  bus
);

    localparam int unsigned CNT_W = 21;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_P     = 8'h4D;
    localparam logic [7:0] CODE_LARR  = 8'h6B;
    localparam logic [7:0] CODE_RARR  = 8'h74;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 21'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic r_left_n, r_left_e, r_right_n, r_right_e, r_space, r_p;
    logic w_left_n, w_left_e, w_right_n, w_right_e, w_space, w_p;
    logic r_move_left, r_move_right, r_fire, r_pause, r_seq_error;
    logic w_move_left, w_move_right, w_fire, w_pause, w_seq_error;
    logic w_make, w_brk, w_ext;

    // State register, counter, held flags and registered outputs
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_left_n     <= 1'b0;
            r_left_e     <= 1'b0;
            r_right_n    <= 1'b0;
            r_right_e    <= 1'b0;
            r_space      <= 1'b0;
            r_p          <= 1'b0;
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_fire       <= 1'b0;
            r_pause      <= 1'b0;
            r_seq_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_left_n     <= w_left_n;
            r_left_e     <= w_left_e;
            r_right_n    <= w_right_n;
            r_right_e    <= w_right_e;
            r_space      <= w_space;
            r_p          <= w_p;
            r_move_left  <= w_move_left;
            r_move_right <= w_move_right;
            r_fire       <= w_fire;
            r_pause      <= w_pause;
            r_seq_error  <= w_seq_error;
        end
    end

    // Next-state, timeout and key-flag logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_left_n    = r_left_n;
        w_left_e    = r_left_e;
        w_right_n   = r_right_n;
        w_right_e   = r_right_e;
        w_space     = r_space;
        w_p         = r_p;
        w_pause     = r_pause;
        w_fire      = 1'b0;
        w_seq_error = 1'b0;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_ext       = 1'b0;

        if (bus.ps2_valid) begin
            // A byte always wins over a coincident timeout
            w_cnt_nxt = '0;
            unique case (r_state)
                IDLE: begin
                    if (bus.ps2_data == CODE_EXT)      w_state_nxt = EXT;
                    else if (bus.ps2_data == CODE_BRK) w_state_nxt = BRK;
                    else                               w_make      = 1'b1;
                end
                EXT: begin
                    if (bus.ps2_data == CODE_BRK)      w_state_nxt = EXT_BRK;
                    else if (bus.ps2_data != CODE_EXT) begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_brk       = 1'b1;
                    w_state_nxt = IDLE;
                end
                EXT_BRK: begin
                    w_brk       = 1'b1;
                    w_ext       = 1'b1;
                    w_state_nxt = IDLE;
                end
            endcase
        end else if (r_state != IDLE) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = IDLE;
                w_seq_error = 1'b1;
                w_cnt_nxt   = '0;
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        // A flag takes the make bit, so a break on an already-clear flag is a no-op
        if (w_make || w_brk) begin
            if (!w_ext) begin
                case (bus.ps2_data)
                    CODE_A: w_left_n  = w_make;
                    CODE_D: w_right_n = w_make;
                    CODE_SPACE: begin
                        w_space = w_make;
                        w_fire  = w_make && !r_space && !r_pause;
                    end
                    CODE_P: begin
                        w_p = w_make;
                        if (w_make && !r_p) w_pause = ~r_pause;
                    end
                    default: ;
                endcase
            end else begin
                case (bus.ps2_data)
                    CODE_LARR: w_left_e  = w_make;
                    CODE_RARR: w_right_e = w_make;
                    default: ;
                endcase
            end
        end

        w_move_left  = (w_left_n | w_left_e) & ~(w_right_n | w_right_e) & ~w_pause;
        w_move_right = (w_right_n | w_right_e) & ~(w_left_n | w_left_e) & ~w_pause;
    end

    assign bus.move_left  = r_move_left;
    assign bus.move_right = r_move_right;
    assign bus.fire       = r_fire;
    assign bus.pause      = r_pause;
    assign bus.seq_error  = r_seq_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table plus timeout, coincidence and reset sequences.
module tb_ps2_key_decoder;

    localparam logic [20:0] TO = 21'd16;

    typedef struct packed {
        logic ml;
        logic mr;
        logic fire;
        logic pause;
        logic se;
    } out_t;

    typedef struct {
        logic [7:0] data;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    out_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .bus      (bus)
    );

    function automatic out_t cur();
        out_t r;
        r.ml    = bus.move_left;
        r.mr    = bus.move_right;
        r.fire  = bus.fire;
        r.pause = bus.pause;
        r.se    = bus.seq_error;
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:0] d, input logic [4:0] e);
        vec_t v;
        v.data = d;
        v.exp  = out_t'(e);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (ml mr fire pause se)", nm, act, exp);
        end
    endtask

    // Drive one byte at a negedge; compare the cycle after the strobe, then an idle cycle
    task automatic send(input logic [7:0] b, input logic [4:0] e, input string nm);
        out_t exp_now;
        out_t idle_exp;
        sb_q.push_back(out_t'(e));
        bus.ps2_data  = b;
        bus.ps2_valid = 1'b1;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
        exp_now = sb_q.pop_front();
        chk(nm, 8'(cur()), 8'(exp_now));
        @(negedge clk);
        idle_exp      = exp_now;
        idle_exp.fire = 1'b0;
        idle_exp.se   = 1'b0;
        chk({nm, "_idle"}, 8'(cur()), 8'(idle_exp));
    endtask

    initial begin
        int pulses;
        int highs;
        logic prev_se;

        rst_n         = 1'b0;
        bus.ps2_data  = 8'h00;
        bus.ps2_valid = 1'b0;

        // Vector table, bits = {move_left, move_right, fire, pause, seq_error}
        tbl.push_back(mk(8'h1C, 5'b10000)); tbl.push_back(mk(8'hF0, 5'b10000));
        tbl.push_back(mk(8'h1C, 5'b00000)); tbl.push_back(mk(8'hE0, 5'b00000));
        tbl.push_back(mk(8'h74, 5'b01000)); tbl.push_back(mk(8'h1C, 5'b00000));
        tbl.push_back(mk(8'hF0, 5'b00000)); tbl.push_back(mk(8'h1C, 5'b01000));
        tbl.push_back(mk(8'hE0, 5'b01000)); tbl.push_back(mk(8'hF0, 5'b01000));
        tbl.push_back(mk(8'h74, 5'b00000)); tbl.push_back(mk(8'h29, 5'b00100));
        tbl.push_back(mk(8'h29, 5'b00000)); tbl.push_back(mk(8'h29, 5'b00000));
        tbl.push_back(mk(8'hF0, 5'b00000)); tbl.push_back(mk(8'h29, 5'b00000));
        tbl.push_back(mk(8'h29, 5'b00100)); tbl.push_back(mk(8'hF0, 5'b00000));
        tbl.push_back(mk(8'h29, 5'b00000)); tbl.push_back(mk(8'h4D, 5'b00010));
        tbl.push_back(mk(8'h4D, 5'b00010)); tbl.push_back(mk(8'hF0, 5'b00010));
        tbl.push_back(mk(8'h4D, 5'b00010)); tbl.push_back(mk(8'h1C, 5'b00010));
        tbl.push_back(mk(8'h4D, 5'b10000)); tbl.push_back(mk(8'hF0, 5'b10000));
        tbl.push_back(mk(8'h4D, 5'b10000)); tbl.push_back(mk(8'hF0, 5'b10000));
        tbl.push_back(mk(8'h1C, 5'b00000)); tbl.push_back(mk(8'h4D, 5'b00010));
        tbl.push_back(mk(8'h29, 5'b00010)); tbl.push_back(mk(8'hF0, 5'b00010));
        tbl.push_back(mk(8'h29, 5'b00010)); tbl.push_back(mk(8'hF0, 5'b00010));
        tbl.push_back(mk(8'h4D, 5'b00010)); tbl.push_back(mk(8'h4D, 5'b00000));
        tbl.push_back(mk(8'hF0, 5'b00000)); tbl.push_back(mk(8'h4D, 5'b00000));
        tbl.push_back(mk(8'hF0, 5'b00000)); tbl.push_back(mk(8'h23, 5'b00000));
        tbl.push_back(mk(8'hE0, 5'b00000)); tbl.push_back(mk(8'hE0, 5'b00000));
        tbl.push_back(mk(8'h6B, 5'b10000)); tbl.push_back(mk(8'hE0, 5'b10000));
        tbl.push_back(mk(8'hF0, 5'b10000)); tbl.push_back(mk(8'h6B, 5'b00000));
        tbl.push_back(mk(8'h23, 5'b01000)); tbl.push_back(mk(8'hE0, 5'b01000));
        tbl.push_back(mk(8'h6B, 5'b00000)); tbl.push_back(mk(8'hF0, 5'b00000));
        tbl.push_back(mk(8'h23, 5'b10000)); tbl.push_back(mk(8'hE0, 5'b10000));
        tbl.push_back(mk(8'hF0, 5'b10000)); tbl.push_back(mk(8'h6B, 5'b00000));

        repeat (3) @(negedge clk);
        chk("reset_state", 8'(cur()), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) send(tbl[i].data, 5'(tbl[i].exp), $sformatf("vec%0d", i));

        // Prefix timeout: exactly one single-cycle seq_error, then back in IDLE
        send(8'hE0, 5'b00000, "to_e0");
        pulses  = 0;
        highs   = 0;
        prev_se = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.seq_error) highs++;
            if (bus.seq_error && !prev_se) pulses++;
            prev_se = bus.seq_error;
        end
        chk("to_pulses", 8'(pulses), 8'd1);
        chk("to_width", 8'(highs), 8'd1);
        send(8'h6B, 5'b00000, "to_6b_normal");

        // Byte arriving on the timeout cycle is decoded as extended, no seq_error
        send(8'hE0, 5'b00000, "co_e0");
        repeat (14) @(negedge clk);
        send(8'h6B, 5'b10000, "co_6b_ext");
        send(8'hE0, 5'b10000, "co_rel_e0");
        send(8'hF0, 5'b10000, "co_rel_f0");
        send(8'h6B, 5'b00000, "co_rel_6b");

        // Reset mid-sequence discards the prefix and clears flags and pause
        send(8'h1C, 5'b10000, "rs_1c");
        send(8'h4D, 5'b00010, "rs_4d");
        send(8'hE0, 5'b00010, "rs_e0");
        rst_n = 1'b0;
        #1;
        chk("rs_async", 8'(cur()), 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("rs_held", 8'(cur()), 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'hF0, 5'b00000, "rs_f0");
        send(8'h6B, 5'b00000, "rs_6b");
        send(8'hE0, 5'b00000, "rs_e0b");
        send(8'h6B, 5'b10000, "rs_ext_6b");
        send(8'hE0, 5'b10000, "rs_rel_e0");
        send(8'hF0, 5'b10000, "rs_rel_f0");
        send(8'h6B, 5'b00000, "rs_rel_6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
